// File: rtl/corr_pkt_sched.sv
// corr_pkt_sched: buffers one result packet per correlator channel, grants round-robin,
// and serializes a header byte plus PKT_BYTES body bytes into a shared 8-bit FIFO.
`default_nettype none

module corr_pkt_sched #(
  parameter  int N_CH      = 4,
  parameter  int PKT_BYTES = 5,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cg,
  input  logic                        i_flush,
  input  logic [N_CH-1:0]             i_req,
  input  logic [N_CH*PKT_BYTES*8-1:0] i_pkt,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_push,
  output logic [7:0]                  o_fifo_data,
  output logic                        o_busy,
  output logic [CH_W-1:0]             o_chIdx,
  output logic [7:0]                  o_dropCount
);

  localparam int PKT_W = PKT_BYTES * 8;
  localparam int BI_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [BI_W-1:0] C_LAST_BYTE = BI_W'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } state_t;

  state_t             r_state;
  logic [PKT_W-1:0]   r_buf [N_CH];
  logic [N_CH-1:0]    r_pend;
  logic [N_CH-1:0]    r_dflag;
  logic [CH_W-1:0]    r_rr;
  logic [CH_W-1:0]    r_chIdx;
  logic [PKT_W-1:0]   r_shift;
  logic               r_hdrDrop;
  logic [BI_W-1:0]    r_byteIdx;
  logic [7:0]         r_dropCnt;

  logic               w_found;
  logic [CH_W-1:0]    w_winner;
  logic [N_CH-1:0]    w_grantVec;
  logic [N_CH-1:0]    w_dropVec;
  logic [7:0]         w_dropN;
  logic [9:0]         w_dropSum;
  logic [7:0]         w_dropSat;

  // Round-robin search: descending loop so the nearest index after r_rr is assigned last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = N_CH; k >= 1; k--) begin
      int s;
      s = int'(r_rr) + k;
      if (s >= N_CH) s = s - N_CH;
      if (r_pend[s]) begin
        w_found  = 1'b1;
        w_winner = CH_W'(s);
      end
    end
  end

  always_comb begin
    w_grantVec = '0;
    if (r_state == S_IDLE && w_found) w_grantVec[w_winner] = 1'b1;
    w_dropVec = i_req & r_pend & ~w_grantVec;
    w_dropN   = '0;
    for (int c = 0; c < N_CH; c++) w_dropN = w_dropN + 8'(w_dropVec[c]);
    w_dropSum = {2'b00, r_dropCnt} + {2'b00, w_dropN};
    w_dropSat = (w_dropSum > 10'd255) ? 8'hFF : w_dropSum[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_cg && !i_flush) begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_req[c]) r_buf[c] <= i_pkt[c*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_dflag   <= '0;
      r_rr      <= CH_W'(N_CH - 1);
      r_chIdx   <= '0;
      r_shift   <= '0;
      r_hdrDrop <= 1'b0;
      r_byteIdx <= '0;
      r_dropCnt <= '0;
    end else if (i_cg) begin
      if (i_flush) begin
        r_state   <= S_IDLE;
        r_pend    <= '0;
        r_dflag   <= '0;
        r_dropCnt <= '0;
      end else begin
        // A grant and a fresh request on the same channel leave it pending with no drop.
        r_pend    <= (r_pend & ~w_grantVec) | i_req;
        r_dflag   <= (r_dflag & ~w_grantVec) | w_dropVec;
        r_dropCnt <= w_dropSat;
        case (r_state)
          S_IDLE: begin
            if (w_found) begin
              r_shift   <= r_buf[w_winner];
              r_hdrDrop <= r_dflag[w_winner];
              r_rr      <= w_winner;
              r_chIdx   <= w_winner;
              r_state   <= S_HDR;
            end
          end
          S_HDR: begin
            if (!i_fifo_full) begin
              r_byteIdx <= '0;
              r_state   <= S_BODY;
            end
          end
          S_BODY: begin
            if (!i_fifo_full) begin
              r_shift <= r_shift >> 8;
              if (r_byteIdx == C_LAST_BYTE) r_state <= S_IDLE;
              else r_byteIdx <= r_byteIdx + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (r_state)
      S_HDR:   o_fifo_data = {r_hdrDrop, 7'(r_chIdx)};
      S_BODY:  o_fifo_data = r_shift[7:0];
      default: o_fifo_data = 8'h00;
    endcase
  end

  assign o_fifo_push = i_cg & ~i_flush & ~i_fifo_full & ((r_state == S_HDR) | (r_state == S_BODY));
  assign o_busy      = (r_state != S_IDLE);
  assign o_chIdx     = r_chIdx;
  assign o_dropCount = r_dropCnt;

endmodule

`default_nettype wire

// File: tb/tb_corr_pkt_sched.sv
// tb_corr_pkt_sched: directed and random stimulus against a packet-level reference model.
`default_nettype none

module tb_corr_pkt_sched;

  localparam int N  = 4;
  localparam int PB = 5;
  localparam int PW = PB * 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cg, flush, full;
  logic [N-1:0]    req;
  logic [N*PW-1:0] pkt;
  logic            push;
  logic [7:0]      data;
  logic            busy;
  logic [1:0]      chIdx;
  logic [7:0]      dropCount;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int first_push;
  logic [7:0] got [$];

  // Reference model: a packet is "bytes left to send"; 0 means idle.
  int           m_left;
  int           m_ch;
  int           m_rr;
  logic         m_hdr;
  logic [PW-1:0] m_body;
  logic [PW-1:0] m_buf [N];
  logic [N-1:0] m_pend, m_dflag;
  int           m_drops;

  corr_pkt_sched #(.N_CH(N), .PKT_BYTES(PB)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_flush(flush), .i_req(req), .i_pkt(pkt),
    .i_fifo_full(full), .o_fifo_push(push), .o_fifo_data(data), .o_busy(busy),
    .o_chIdx(chIdx), .o_dropCount(dropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_ch = 0; m_rr = N - 1; m_hdr = 1'b0; m_body = '0;
    m_pend = '0; m_dflag = '0; m_drops = 0;
  endtask

  function automatic logic [7:0] exp_data();
    if (m_left == 0) return 8'h00;
    if (m_left == PB + 1) return {m_hdr, 7'(m_ch)};
    return m_body[(PB - m_left)*8 +: 8];
  endfunction

  task automatic model_update();
    logic [N-1:0] old;
    int gw, n, s;
    if (!cg) return;
    if (flush) begin
      m_left = 0; m_pend = '0; m_dflag = '0; m_drops = 0;
      return;
    end
    old = m_pend;
    gw  = -1;
    if (m_left == 0) begin
      for (int k = 1; k <= N; k++) begin
        s = (m_rr + k) % N;
        if (gw < 0 && old[s]) gw = s;
      end
      if (gw >= 0) begin
        m_body = m_buf[gw]; m_hdr = m_dflag[gw];
        m_pend[gw] = 1'b0; m_dflag[gw] = 1'b0;
        m_rr = gw; m_ch = gw; m_left = PB + 1;
      end
    end else if (!full) begin
      m_left--;
    end
    n = 0;
    for (int c = 0; c < N; c++) begin
      if (req[c]) begin
        if (old[c] && c != gw) begin
          m_dflag[c] = 1'b1;
          n++;
        end
        m_pend[c] = 1'b1;
        m_buf[c]  = pkt[c*PW +: PW];
      end
    end
    m_drops = (m_drops + n > 255) ? 255 : m_drops + n;
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic f, input logic fl, input logic g,
                     input logic [N*PW-1:0] p);
    logic e_busy;
    @(posedge clk);
    #1;
    req = r; full = f; flush = fl; cg = g; pkt = p;
    @(negedge clk);
    e_busy = (m_left != 0);
    chk("busy", 64'(busy), 64'(e_busy));
    chk("push", 64'(push), 64'(cg && !flush && !full && e_busy));
    chk("data", 64'(data), 64'(exp_data()));
    chk("chIdx", 64'(chIdx), 64'(m_ch));
    chk("dropCount", 64'(dropCount), 64'(m_drops));
    if (push) begin
      got.push_back(data);
      if (first_push < 0) first_push = cyc_n;
    end
    cyc_n++;
    model_update();
  endtask

  function automatic logic [N*PW-1:0] rand_pkt();
    logic [N*PW-1:0] p;
    for (int i = 0; i < N*PB; i++) p[i*8 +: 8] = 8'($urandom);
    return p;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_push"}, 64'(push), 64'(0));
    chk({tag, "_data"}, 64'(data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_chIdx"}, 64'(chIdx), 64'(0));
    chk({tag, "_drops"}, 64'(dropCount), 64'(0));
  endtask

  initial begin
    logic [N*PW-1:0] p;
    logic [7:0] exp1 [6];
    logic [N-1:0] r;

    rst = 1'b1; cg = 1'b0; flush = 1'b0; full = 1'b0; req = '0; pkt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single request on ch2: header 0x02 then body bytes LSB first, header two cycles after request.
    p = '0;
    p[2*PW +: PW] = 40'h0504030201;
    got.delete(); first_push = -1; cyc_n = 0;
    cyc(4'b0100, 1'b0, 1'b0, 1'b1, p);
    repeat (9) cyc('0, 1'b0, 1'b0, 1'b1, p);
    exp1 = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk("t1_count", 64'(got.size()), 64'(6));
    chk("t1_latency", 64'(first_push), 64'(2));
    for (int i = 0; i < 6; i++) chk("t1_byte", 64'((i < got.size()) ? got[i] : 8'hxx), 64'(exp1[i]));

    // Burst on all channels, then a second burst: order restarts from ch0.
    repeat (2) begin
      cyc(4'b1111, 1'b0, 1'b0, 1'b1, rand_pkt());
      repeat (30) cyc('0, 1'b0, 1'b0, 1'b1, '0);
    end

    // Request on the grant cycle of the same channel.
    cyc(4'b0010, 1'b0, 1'b0, 1'b1, rand_pkt());
    cyc(4'b0010, 1'b0, 1'b0, 1'b1, rand_pkt());
    repeat (16) cyc('0, 1'b0, 1'b0, 1'b1, '0);
    chk("t6_nodrop", 64'(dropCount), 64'(0));

    // Async reset in the middle of a packet.
    cyc(4'b0001, 1'b0, 1'b0, 1'b1, rand_pkt());
    repeat (4) cyc('0, 1'b0, 1'b0, 1'b1, '0);
    req = '0; cg = 1'b0; flush = 1'b0; full = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic with backpressure, clock gating and occasional flush.
    for (int i = 0; i < 1500; i++) begin
      r = '0;
      for (int c = 0; c < N; c++) r[c] = ($urandom_range(0, 7) == 0);
      cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 15) != 0), rand_pkt());
    end
    cyc('0, 1'b0, 1'b1, 1'b1, '0);

    // Saturation: FIFO full keeps one packet stalled while every channel keeps overwriting.
    for (int i = 0; i < 80; i++) cyc(4'b1111, 1'b1, 1'b0, 1'b1, rand_pkt());
    chk("sat_255", 64'(dropCount), 64'(255));
    cyc('0, 1'b0, 1'b1, 1'b1, '0);
    cyc('0, 1'b0, 1'b0, 1'b1, '0);
    chk("flush_clear", 64'(dropCount), 64'(0));
    chk("flush_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
